tap_delay_line: RTL and testbench
=================================

# tap_delay_line

Parametrised tapped delay line for the LPC sample path. It generalises the fixed 16-bit, 10-stage one-hot-tap shifter to configurable width and depth, and selects taps with a binary index. Storage advances only on qualified input samples. A fill counter reports how much valid history is held, so taps reaching past the valid history return zero. Autocorrelation and the prediction filters use it to read x[n-k] from a frame-synchronous sample stream.

## Interface
- `WIDTH`, default 16: sample width in bits.
- `DEPTH`, default 10: number of storage stages (≥1).
- `TAPW`, default `$clog2(DEPTH+1)`: width of tap and fill; derived, not overridden.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous flush of history (frame start).
- `in_valid`  in  1  `din` carries a new sample this cycle.
- `din`  in  WIDTH  input sample, two's complement (opaque to block).
- `tap`  in  TAPW  binary delay select: 0 = bypass `din`; k = sample k pushes ago.
- `dout`  out  WIDTH  selected sample.
- `dout_valid`  out  1  `dout` holds real data.
- `fill`  out  TAPW  stored valid samples, saturates at DEPTH.
- `full`  out  1  `fill == DEPTH`.

## Operation
- Storage: stages s[1..DEPTH], where s[1] is the newest sample.
- On `in_valid`: s[1]←din, and s[i]←s[i-1] for i=2..DEPTH. The oldest sample is discarded.
- With no `in_valid`, storage holds its contents (no shifting on idle cycles).
- `fill` increments on each `in_valid` until it reaches DEPTH, then holds at DEPTH.
- On `clr` without `in_valid`: all stages are set to 0 and `fill`←0.
- On `clr` with `in_valid` in the same cycle:
  - all stages clear, except s[1]←din;
  - `fill`←1;
  - the sample becomes the first sample of the new frame.
- Tap decode:
  - `tap`=0 → `dout`=`din`, `dout_valid`=`in_valid`.
  - 1≤`tap`≤`fill` → `dout`=s[tap], `dout_valid`=1.
  - `tap`>`fill`, or `tap`>DEPTH → `dout`=0, `dout_valid`=0. Out-of-range taps are never an X source.
- Reset (`rst_n`=0, asynchronous): all stages 0, `fill`=0, `full`=0, `dout`=0, `dout_valid`=0.
  - Reset asserted mid-stream discards all history immediately.
  - The first `in_valid` after deassertion writes s[1].
- Arithmetic: `fill` is unsigned and never wraps. Samples are passed through bit-exact; there is no sign extension or rounding.

## Timing
- Single clock domain. All state updates on the rising edge of `clk`.
- Combinational mode (default):
  - `dout`/`dout_valid` depend on current `tap`, `din`, `in_valid` and storage as updated by previous edges.
  - Latency from `tap` to `dout` is 0 cycles.
  - A sample pushed at edge E is readable at `tap`=1 from just after E.
- `fill`/`full` are registered and reflect edges up to and including the last one.
- `tap` may change every cycle. There is no handshake or backpressure; the block always accepts `in_valid`.
- Storage is initialised only by reset or `clr`.

## Configuration
- `TAP_DELAY_LINE_OUT_REG_EN` defined:
  - `dout` and `dout_valid` are registered. On each edge they capture the decode result computed from pre-edge `tap`/`din`/`in_valid`/storage/`fill`.
  - Latency is 1 cycle.
  - The output registers reset to 0 asynchronously.
  - `clr` does not clear the output register; it updates on the next edge like any other cycle.
- `TAP_DELAY_LINE_OUT_REG_EN` undefined: fully combinational decode as described under Timing. `fill`/`full` are unaffected either way.

## Test plan
- Reset then fill: WIDTH=16, DEPTH=10. Push 0x0001..0x000C on consecutive cycles.
  - → `fill` 1..10, then holds at 10.
  - `full`=1 after the 10th push.
  - `tap`=10 reads 0x0003 after all 12 pushes.
- Partial history: after 3 pushes (0xA, 0xB, 0xC):
  - `tap`=3 → 0x000A, valid=1.
  - `tap`=4 → 0, valid=0.
  - `tap`=15 → 0, valid=0.
- Gapped input: push 0x1111, idle 5 cycles, push 0x2222.
  - → `tap`=2 reads 0x1111; storage unchanged during idle cycles.
- Bypass: `tap`=0, `din`=0xBEEF.
  - `in_valid`=1 → `dout`=0xBEEF, valid=1.
  - `in_valid`=0 → `dout`=0xBEEF, valid=0.
- Flush collisions on a full line:
  - `clr`+`in_valid` with `din`=0x5555 → `fill`=1, `tap`=1 reads 0x5555, `tap`=2 reads 0 with valid=0.
  - `clr` alone → `fill`=0.
  - `rst_n` pulse mid-stream → all outputs 0 asynchronously.
- Registered build (`TAP_DELAY_LINE_OUT_REG_EN`): repeat the partial-history scenario.
  - → each response appears exactly one cycle later.
  - `dout` is 0 in the first cycle after reset release.

Source files
------------

// File: rtl/tap_delay_line.sv
// tap_delay_line: parametrised tapped delay line for the LPC sample path.
//
// Holds the last DEPTH qualified samples and returns the sample pushed `tap`
// pushes ago (tap 0 bypasses din). A fill counter tracks how much valid
// history is stored so that taps reaching past it read as zero/invalid.
//
// Parameters:
//   WIDTH  sample width in bits
//   DEPTH  number of storage stages (>= 1)
//   TAPW   width of tap/fill, derived as $clog2(DEPTH+1)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   clr         synchronous history flush (frame start)
//   in_valid    din carries a new sample this cycle
//   din         input sample (opaque, passed bit-exact)
//   tap         binary delay select
//   dout        selected sample
//   dout_valid  dout holds real data
//   fill        number of valid stored samples, saturates at DEPTH
//   full        fill == DEPTH
//
// Build option:
//   TAP_DELAY_LINE_OUT_REG_EN  when defined, dout/dout_valid are registered
//                              (1-cycle latency); otherwise decode is
//                              combinational.

module tap_delay_line #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 10,
  localparam int unsigned TAPW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  input  logic [TAPW-1:0]  tap,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [TAPW-1:0]  fill,
  output logic             full
);

  localparam logic [TAPW-1:0] DEPTH_T = TAPW'(DEPTH);
  localparam logic [TAPW-1:0] ONE_T   = TAPW'(1);

  // stage_q[0] is s[1] (newest), stage_q[DEPTH-1] is s[DEPTH] (oldest)
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [TAPW-1:0]  fill_q;
  logic [TAPW-1:0]  fill_nxt;
  logic             full_q;
  logic [WIDTH-1:0] dec_data;
  logic             dec_valid;

  // Sample storage: shifts only on qualified samples; clr flushes, but a
  // coincident sample survives as the first sample of the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      if (in_valid) begin
        stage_q[0] <= din;
      end
    end else if (in_valid) begin
      stage_q[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Next fill: saturating count of stored samples, restarted by clr.
  always_comb begin
    fill_nxt = fill_q;
    if (clr) begin
      fill_nxt = in_valid ? ONE_T : '0;
    end else if (in_valid && (fill_q != DEPTH_T)) begin
      fill_nxt = fill_q + ONE_T;
    end
  end

  // Fill/full registers; full is registered from the same next value so the
  // two outputs never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      full_q <= 1'b0;
    end else begin
      fill_q <= fill_nxt;
      full_q <= (fill_nxt == DEPTH_T);
    end
  end

  assign fill = fill_q;
  assign full = full_q;

  // Tap decode. fill_q never exceeds DEPTH, so tap <= fill_q also bounds the
  // stage index; the compare loop keeps out-of-range taps from reading X.
  always_comb begin
    dec_data  = '0;
    dec_valid = 1'b0;
    if (tap == '0) begin
      dec_data  = din;
      dec_valid = in_valid;
    end else if (tap <= fill_q) begin
      dec_valid = 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (tap == TAPW'(i + 1)) begin
          dec_data = stage_q[i];
        end
      end
    end
  end

`ifdef TAP_DELAY_LINE_OUT_REG_EN
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;

  // Output register captures the pre-edge decode; clr has no effect here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_q       <= dec_data;
      dout_valid_q <= dec_valid;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
`else
  assign dout       = dec_data;
  assign dout_valid = dec_valid;
`endif

endmodule

// File: tb/tb_tap_delay_line.sv
// Scoreboard bench for tap_delay_line (WIDTH=16, DEPTH=10).
// Stimulus pushes hand-computed expectations tagged with the cycle in which
// they must be visible; a negedge monitor pops and compares them.

module tb_tap_delay_line;

`ifdef TAP_DELAY_LINE_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [15:0] din;
  logic [3:0]  tap;
  logic [15:0] dout;
  logic        dout_valid;
  logic [3:0]  fill;
  logic        full;

  tap_delay_line #(.WIDTH(16), .DEPTH(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .din        (din),
    .tap        (tap),
    .dout       (dout),
    .dout_valid (dout_valid),
    .fill       (fill),
    .full       (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       nm;
    bit          kind;  // 0: dout/dout_valid, 1: fill/full
    logic [15:0] d;
    logic        v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due this cycle; stale ones are misses.
  always @(negedge clk) begin
    for (int i = 0; i < q.size(); ) begin
      if (q[i].cyc == cyc) begin
        logic [15:0] ad;
        logic        av;
        ad = q[i].kind ? 16'(fill) : dout;
        av = q[i].kind ? full : dout_valid;
        n_tests++;
        if (ad !== q[i].d || av !== q[i].v) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got d=%h v=%b expected d=%h v=%b",
                   q[i].nm, cyc, ad, av, q[i].d, q[i].v);
        end
        q.delete(i);
      end else if (q[i].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s never compared (due cyc=%0d, now %0d)", q[i].nm, q[i].cyc, cyc);
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs; optionally expect a decode result LAT cycles on.
  task automatic drive(input logic iv, input logic [15:0] d, input logic [3:0] t,
                       input logic c, input bit chk, input logic [15:0] ed,
                       input logic ev, input string nm);
    exp_t e;
    in_valid = iv;
    din      = d;
    tap      = t;
    clr      = c;
    if (chk) begin
      e.cyc = cyc + LAT; e.nm = nm; e.kind = 1'b0; e.d = ed; e.v = ev;
      q.push_back(e);
    end
  endtask

  // Expectation on the current cycle (fill/full, or async-reset outputs).
  task automatic expect_now(input bit kind, input logic [15:0] ed, input logic ev,
                            input string nm);
    exp_t e;
    e.cyc = cyc; e.nm = nm; e.kind = kind; e.d = ed; e.v = ev;
    q.push_back(e);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; din = '0; tap = '0;

    // Reset state
    tick();
    drive(1'b0, 16'h0, 4'd0, 1'b0, 1'b1, 16'h0, 1'b0, "rst_dout");
    expect_now(1'b1, 16'd0, 1'b0, "rst_fill");
    tick();
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 4'd0, 1'b0, 1'b1, 16'h0, 1'b0, "rel_dout");

    // Fill 0x0001..0x000C through bypass tap
    for (k = 1; k <= 12; k++) begin
      tick();
      drive(1'b1, 16'(k), 4'd0, 1'b0, 1'b1, 16'(k), 1'b1, "fill_bypass");
      expect_now(1'b1, 16'((k - 1 > 10) ? 10 : k - 1), (k - 1 >= 10), "fill_cnt");
    end
    tick();
    drive(1'b0, 16'h0, 4'd10, 1'b0, 1'b1, 16'h0003, 1'b1, "tap10_oldest");
    expect_now(1'b1, 16'd10, 1'b1, "fill_sat");
    tick();
    drive(1'b0, 16'h0, 4'd1, 1'b0, 1'b1, 16'h000C, 1'b1, "tap1_newest");
    expect_now(1'b1, 16'd10, 1'b1, "fill_hold");

    // Gapped input: storage holds across idle cycles
    tick();
    drive(1'b1, 16'h1111, 4'd0, 1'b0, 1'b1, 16'h1111, 1'b1, "gap_push1");
    for (k = 0; k < 5; k++) begin
      tick();
      drive(1'b0, 16'hFFFF, 4'd1, 1'b0, 1'b1, 16'h1111, 1'b1, "gap_idle");
    end
    tick();
    drive(1'b1, 16'h2222, 4'd1, 1'b0, 1'b1, 16'h1111, 1'b1, "gap_push2");
    tick();
    drive(1'b0, 16'h0, 4'd2, 1'b0, 1'b1, 16'h1111, 1'b1, "gap_tap2");
    tick();
    drive(1'b0, 16'h0, 4'd1, 1'b0, 1'b1, 16'h2222, 1'b1, "gap_tap1");

    // Bypass with and without in_valid
    tick();
    drive(1'b1, 16'hBEEF, 4'd0, 1'b0, 1'b1, 16'hBEEF, 1'b1, "byp_valid");
    tick();
    drive(1'b0, 16'hBEEF, 4'd0, 1'b0, 1'b1, 16'hBEEF, 1'b0, "byp_idle");

    // Flush collisions on a full line
    tick();
    drive(1'b1, 16'h5555, 4'd0, 1'b1, 1'b1, 16'h5555, 1'b1, "clr_iv_byp");
    expect_now(1'b1, 16'd10, 1'b1, "pre_clr_full");
    tick();
    drive(1'b0, 16'h0, 4'd1, 1'b0, 1'b1, 16'h5555, 1'b1, "clr_iv_tap1");
    expect_now(1'b1, 16'd1, 1'b0, "clr_iv_fill");
    tick();
    drive(1'b0, 16'h0, 4'd2, 1'b0, 1'b1, 16'h0, 1'b0, "clr_iv_tap2");
    tick();
    drive(1'b0, 16'h0, 4'd1, 1'b1, 1'b1, 16'h5555, 1'b1, "clr_pre");
    tick();
    drive(1'b0, 16'h0, 4'd1, 1'b0, 1'b1, 16'h0, 1'b0, "clr_tap1");
    expect_now(1'b1, 16'd0, 1'b0, "clr_fill");

    // Partial history
    tick();
    drive(1'b1, 16'h000A, 4'd0, 1'b0, 1'b1, 16'h000A, 1'b1, "part_push_a");
    tick();
    drive(1'b1, 16'h000B, 4'd1, 1'b0, 1'b1, 16'h000A, 1'b1, "part_push_b");
    tick();
    drive(1'b1, 16'h000C, 4'd2, 1'b0, 1'b1, 16'h000A, 1'b1, "part_push_c");
    expect_now(1'b1, 16'd2, 1'b0, "part_fill2");
    tick();
    drive(1'b0, 16'h0, 4'd3, 1'b0, 1'b1, 16'h000A, 1'b1, "part_tap3");
    expect_now(1'b1, 16'd3, 1'b0, "part_fill3");
    tick();
    drive(1'b0, 16'h0, 4'd4, 1'b0, 1'b1, 16'h0, 1'b0, "part_tap4");
    tick();
    drive(1'b0, 16'h0, 4'd15, 1'b0, 1'b1, 16'h0, 1'b0, "part_tap15");
    tick();
    drive(1'b0, 16'h0, 4'd1, 1'b0, 1'b1, 16'h000C, 1'b1, "part_tap1");

    // Asynchronous reset mid-stream
    tick();
    drive(1'b1, 16'h0077, 4'd1, 1'b0, 1'b0, 16'h0, 1'b0, "");
    tick();
    drive(1'b0, 16'h0, 4'd1, 1'b0, 1'b0, 16'h0, 1'b0, "");
    #1;
    rst_n = 1'b0;
    expect_now(1'b0, 16'h0, 1'b0, "async_rst_dout");
    expect_now(1'b1, 16'd0, 1'b0, "async_rst_fill");
    tick();
    rst_n = 1'b1;
    drive(1'b1, 16'h0099, 4'd0, 1'b0, 1'b1, 16'h0099, 1'b1, "post_rst_push");
    expect_now(1'b1, 16'd0, 1'b0, "post_rst_fill0");
    tick();
    drive(1'b0, 16'h0, 4'd1, 1'b0, 1'b1, 16'h0099, 1'b1, "post_rst_tap1");
    expect_now(1'b1, 16'd1, 1'b0, "post_rst_fill1");
    tick();
    drive(1'b0, 16'h0, 4'd2, 1'b0, 1'b1, 16'h0, 1'b0, "post_rst_tap2");

    // Drain the scoreboard, bounded
    for (k = 0; k < 10 && q.size() > 0; k++) tick();
    while (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timed out (due cyc=%0d)", q[0].nm, q[0].cyc);
      void'(q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
